// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush, stall/memory-stall freeze and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
  parameter bit                   SKID       = 1'b1,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              memStall_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              dn_valid_q, dn_valid_d;
  logic [DATA_W-1:0] dn_data_q, dn_data_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hold, consume, accept, load_main;

  assign hold    = stall_i | memStall_i;
  assign consume = dn_valid_q & dn_ready_i & ~hold;
  assign accept  = up_valid_i & up_ready_o;
  // Main may only be (re)loaded when it is empty or draining, and never while held.
  assign load_main = ~hold & (~dn_valid_q | dn_ready_i);

  always_comb begin
    if (SKID) begin
      up_ready_o = ~skid_v_q;
    end else begin
      up_ready_o = load_main;
    end
  end

  always_comb begin
    dn_valid_d  = dn_valid_q;
    dn_data_d   = dn_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      dn_valid_d = 1'b0;
      dn_data_d  = BUBBLE_VAL;
      skid_v_d   = 1'b0;
    end else if (SKID) begin
      if (load_main) begin
        if (skid_v_q) begin
          dn_valid_d = 1'b1;
          dn_data_d  = skid_data_q;
          skid_v_d   = 1'b0;
        end else if (accept) begin
          dn_valid_d = 1'b1;
          dn_data_d  = up_data_i;
        end else begin
          dn_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_v_d    = 1'b1;
        skid_data_d = up_data_i;
      end
    end else begin
      if (accept) begin
        dn_valid_d = 1'b1;
        dn_data_d  = up_data_i;
      end else if (consume) begin
        dn_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && dn_valid_q && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dn_valid_q  <= 1'b0;
      dn_data_q   <= BUBBLE_VAL;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      dn_valid_q  <= dn_valid_d;
      dn_data_q   <= dn_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dn_valid_o  = dn_valid_q;
  assign dn_data_o   = dn_data_q;
  assign occ_o       = 2'(dn_valid_q) + 2'(skid_v_q);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised scoreboard bench for pipe_stage_reg in skid, no-skid and 4-bit-counter
// builds.
module tb_pipe_stage_reg;

  localparam logic [63:0] BUB = 64'hB0B0_CAFE_0000_0001;

  logic        clk = 1'b0;
  logic        rst, flush, stall, mstall, up_valid, dn_ready;
  logic [63:0] up_data;
  logic        s_up_ready, s_dn_valid;
  logic [63:0] s_dn_data;
  logic [1:0]  s_occ;
  logic [15:0] s_cnt;

  logic        f_up_ready, f_dn_valid;
  logic [63:0] f_dn_data;
  logic [1:0]  f_occ;
  logic [3:0]  f_cnt;

  logic        n_stall, n_mstall, n_valid, n_ready;
  logic [15:0] n_data;
  logic        n_up_ready, n_dn_valid;
  logic [15:0] n_dn_data;
  logic [1:0]  n_occ;
  logic [15:0] n_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] q[$];
  logic [15:0] nq[$];
  logic        s_acc, n_acc;
  int          n_cons;
  logic [63:0] popped;
  logic [15:0] npopped;
  logic [15:0] c0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall), .memStall_i(mstall),
    .up_valid_i(up_valid), .up_ready_o(s_up_ready), .up_data_i(up_data),
    .dn_valid_o(s_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(s_dn_data),
    .occ_o(s_occ), .stall_cnt_o(s_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .SKID(1'b1), .CNT_W(4)) u_cnt4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall), .memStall_i(mstall),
    .up_valid_i(up_valid), .up_ready_o(f_up_ready), .up_data_i(up_data),
    .dn_valid_o(f_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(f_dn_data),
    .occ_o(f_occ), .stall_cnt_o(f_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .BUBBLE_VAL(16'h0), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .stall_i(n_stall), .memStall_i(n_mstall),
    .up_valid_i(n_valid), .up_ready_o(n_up_ready), .up_data_i(n_data),
    .dn_valid_o(n_dn_valid), .dn_ready_i(n_ready), .dn_data_o(n_dn_data),
    .occ_o(n_occ), .stall_cnt_o(n_cnt)
  );

  // Scoreboard sampling on the falling edge, then advance to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    s_acc = 1'b0;
    n_acc = 1'b0;
    if (rst) begin
      q.delete();
      nq.delete();
    end else begin
      if (flush) begin
        q.delete();
      end else begin
        if (s_dn_valid && dn_ready && !(stall || mstall)) begin
          if (q.size() == 0) begin
            chk("sb_underflow", s_dn_valid, 0);
          end else begin
            popped = q.pop_front();
            chk("sb_data", s_dn_data, popped);
          end
        end
        if (up_valid && s_up_ready) begin
          q.push_back(up_data);
          s_acc = 1'b1;
        end
      end
      if (n_stall || n_mstall) chk("n_ready_hold", n_up_ready, 0);
      chk("n_occ_le1", n_occ[1], 0);
      if (n_dn_valid && n_ready && !(n_stall || n_mstall)) begin
        n_cons++;
        if (nq.size() == 0) begin
          chk("n_sb_underflow", n_dn_valid, 0);
        end else begin
          npopped = nq.pop_front();
          chk("n_sb_data", n_dn_data, npopped);
        end
      end
      if (n_valid && n_up_ready) begin
        nq.push_back(n_data);
        n_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [63:0] src;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; mstall = 1'b0;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    n_stall = 1'b0; n_mstall = 1'b0; n_valid = 1'b0; n_ready = 1'b0; n_data = '0;
    n_cons = 0;
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    chk("rst_valid", s_dn_valid, 0);
    chk("rst_data", s_dn_data, BUB);
    chk("rst_ready", s_up_ready, 1);
    chk("rst_occ", s_occ, 0);
    chk("rst_cnt", s_cnt, 0);

    // Full-rate stream of 0x1..0x8.
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = 64'(i); dn_ready = 1'b1;
      cyc();
      chk("str_valid", s_dn_valid, 1);
      chk("str_data", s_dn_data, 64'(i));
      chk("str_occ", s_occ, 1);
    end
    up_valid = 1'b0;
    cyc();
    chk("str_drain", s_dn_valid, 0);
    chk("str_sb_empty", q.size(), 0);

    // Downstream backpressure for 3 cycles: skid captures one beat.
    up_valid = 1'b1; up_data = 64'h11; dn_ready = 1'b1;
    cyc();
    dn_ready = 1'b0; up_data = 64'h12;
    cyc();
    chk("skid_occ", s_occ, 2);
    chk("skid_ready", s_up_ready, 0);
    chk("skid_main", s_dn_data, 64'h11);
    up_data = 64'h13;
    cyc();
    cyc();
    chk("skid_occ_hold", s_occ, 2);
    chk("skid_main_hold", s_dn_data, 64'h11);
    dn_ready = 1'b1;
    src = 64'h13;
    for (int i = 0; i < 6; i++) begin
      up_data = src;
      cyc();
      if (s_acc) src = src + 64'd1;
    end
    up_valid = 1'b0;
    repeat (3) cyc();
    chk("skid_sb_empty", q.size(), 0);
    chk("skid_drained", s_dn_valid, 0);

    // stall_i then memStall_i, 5 cycles each, with valid data held.
    up_valid = 1'b1; up_data = 64'h40; dn_ready = 1'b0;
    cyc();
    up_valid = 1'b0; dn_ready = 1'b1; stall = 1'b1;
    c0 = s_cnt;
    repeat (5) begin
      cyc();
      chk("stall_data", s_dn_data, 64'h40);
    end
    chk("stall_cnt", s_cnt, c0 + 16'd5);
    stall = 1'b0; mstall = 1'b1;
    c0 = s_cnt;
    repeat (5) begin
      cyc();
      chk("mstall_data", s_dn_data, 64'h40);
    end
    chk("mstall_cnt", s_cnt, c0 + 16'd5);
    mstall = 1'b0;
    cyc();
    chk("stall_release", s_dn_valid, 0);

    // Flush with both entries full while held.
    up_valid = 1'b1; up_data = 64'h50; dn_ready = 1'b0;
    cyc();
    stall = 1'b1; up_data = 64'h51;
    cyc();
    chk("fl_occ2", s_occ, 2);
    chk("fl_ready0", s_up_ready, 0);
    chk("fl_main", s_dn_data, 64'h50);
    c0 = s_cnt;
    flush = 1'b1; up_data = 64'h52;
    cyc();
    flush = 1'b0; stall = 1'b0; up_valid = 1'b0;
    chk("fl_valid", s_dn_valid, 0);
    chk("fl_data", s_dn_data, BUB);
    chk("fl_occ", s_occ, 0);
    chk("fl_ready", s_up_ready, 1);
    chk("fl_cnt", s_cnt, c0);

    // Flush drops a beat accepted in the same cycle; the next beat is accepted right after.
    up_valid = 1'b1; up_data = 64'h60; dn_ready = 1'b0;
    cyc();
    flush = 1'b1; up_data = 64'h61;
    cyc();
    flush = 1'b0;
    chk("fl_drop_valid", s_dn_valid, 0);
    chk("fl_drop_occ", s_occ, 0);
    up_data = 64'h70; dn_ready = 1'b1;
    cyc();
    chk("fl_next_valid", s_dn_valid, 1);
    chk("fl_next_data", s_dn_data, 64'h70);
    up_valid = 1'b0;
    cyc();
    chk("fl_sb_empty", q.size(), 0);

    // Counter saturation: hold 20 cycles with valid data.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    up_valid = 1'b1; up_data = 64'h80; dn_ready = 1'b0;
    cyc();
    up_valid = 1'b0; stall = 1'b1;
    repeat (20) cyc();
    chk("sat_cnt4", f_cnt, 15);
    chk("sat_cnt16", s_cnt, 20);
    cyc();
    chk("sat_cnt4_stay", f_cnt, 15);
    stall = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("sat_rst_cnt4", f_cnt, 0);
    chk("sat_rst_cnt16", s_cnt, 0);
    chk("sat_rst_valid", s_dn_valid, 0);
    chk("sat_rst_occ", s_occ, 0);

    // No-skid build: 200 beats with random backpressure and stalls.
    src = '0;
    for (int c = 0; c < 3000 && n_cons < 200; c++) begin
      if (src < 64'd200) begin
        n_valid  = ($urandom_range(0, 3) != 0);
        n_ready  = 1'($urandom_range(0, 1));
        n_stall  = ($urandom_range(0, 5) == 0);
        n_mstall = ($urandom_range(0, 7) == 0);
      end else begin
        n_valid = 1'b0; n_ready = 1'b1; n_stall = 1'b0; n_mstall = 1'b0;
      end
      n_data = 16'hA000 + src[15:0];
      cyc();
      if (n_acc) src = src + 64'd1;
    end
    chk("n_beats", n_cons, 200);
    chk("n_sb_empty", nq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the CPU datapath, the generalised successor of the fixed IF/ID latch. It carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake, an optional 2-entry skid buffer for a registered `up_ready_o`, and flush and stall/memory-stall control. A saturating stall-cycle counter supports performance monitoring. It is instantiated for IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- DATA_W, 64: payload width, for example PC plus instruction.
- BUBBLE_VAL, {DATA_W{1'b0}}: value loaded into `dn_data_o` on reset and on flush.
- SKID, 1: 1 selects the 2-entry skid buffer with registered `up_ready_o`; 0 selects a single register with combinational `up_ready_o`.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all held and incoming data this cycle.
- stall_i  in  1  hazard stall; freezes the output register.
- memStall_i  in  1  memory stall; same effect as `stall_i`.
- up_valid_i  in  1  upstream payload valid.
- up_ready_o  out  1  stage can accept upstream payload.
- up_data_i  in  DATA_W  upstream payload.
- dn_valid_o  out  1  output payload valid.
- dn_ready_i  in  1  downstream accepts output.
- dn_data_o  out  DATA_W  output payload.
- occ_o  out  2  entries held, 0..2 (never exceeds 1 when SKID=0).
- stall_cnt_o  out  CNT_W  saturating count of stalled-valid cycles.

## Operation
- Definitions:
  - hold = stall_i | memStall_i.
  - consume = dn_valid_o & dn_ready_i & !hold.
  - accept = up_valid_i & up_ready_o.
- Storage: the main register drives `dn_valid_o`/`dn_data_o`. The skid register (skid_v, skid_d) exists only when SKID=1.
- Priority per cycle: rst_i, then flush_i, then normal update.
- Reset:
  - dn_valid_o=0, dn_data_o=BUBBLE_VAL, skid_v=0.
  - up_ready_o=1, occ_o=0, stall_cnt_o=0.
- Flush, which overrides hold (unlike the old latch):
  - dn_valid_o=0, dn_data_o=BUBBLE_VAL, skid_v=0.
  - Any payload accepted in the flush cycle is dropped.
  - stall_cnt_o is unchanged.
- Normal update, SKID=1:
  - If !dn_valid_o or consume:
    - skid_v=1: main takes skid_d with valid 1; skid_v becomes 0.
    - Otherwise, accept: main takes up_data_i with valid 1.
    - Otherwise: dn_valid_o becomes 0 and dn_data_o keeps its value.
  - Otherwise, main is full and not consumed. On accept, skid_d takes up_data_i and skid_v becomes 1.
  - up_ready_o = !skid_v, taken from a register.
- Normal update, SKID=0:
  - up_ready_o = !hold & (!dn_valid_o | dn_ready_i), combinational.
  - Main takes up_data_i on accept.
  - On consume without accept, dn_valid_o becomes 0.
- occ_o = dn_valid_o + skid_v.
- stall_cnt_o increments when hold & dn_valid_o & !flush_i. It saturates at 2^CNT_W-1 and does not wrap.
- While hold=1, the main register is frozen. With SKID=1 one extra upstream beat may still land in skid.
- Payload order is strictly preserved; there is no duplication or loss except on flush.

## Timing
- Latency: 1 cycle from accept to dn_valid_o=1. With a skid hit, the payload appears one cycle after the main register drains.
- Throughput: 1 beat/cycle when dn_ready_i=1 and hold=0.
- SKID=1: up_ready_o depends on no same-cycle input. It falls the cycle after skid fills and rises the cycle after skid drains.
- Flush asserted in cycle N gives dn_valid_o=0 and occ_o=0 in cycle N+1. The next accept is possible in cycle N+1.
- Reset mid-transfer: all state is lost and outputs take reset values at the next edge.
- Simultaneous consume and accept with skid empty: main is replaced in the same edge, so there is no bubble.
- The hold/dn_ready_i distinction is visible only in stall_cnt_o and in the SKID=0 up_ready_o equation.

## Test plan
- Reset, then stream 8 beats (0x1..0x8) with up_valid_i=1 and dn_ready_i=1 -> dn_data_o = 0x1..0x8 on consecutive cycles, 1-cycle latency, occ_o=1 throughout.
- SKID=1, dn_ready_i=0 for 3 cycles during a stream -> skid captures 1 beat, occ_o=2, up_ready_o=0 the following cycle. On release the output order is unbroken with no loss.
- stall_i=1 for 5 cycles with dn_valid_o=1 -> dn_data_o held constant and stall_cnt_o +5. Repeat with memStall_i for an identical result.
- flush_i with occ_o=2 while hold=1 -> next cycle dn_valid_o=0, dn_data_o=BUBBLE_VAL, occ_o=0, and the concurrent upstream beat is dropped.
- CNT_W=4, hold 20 cycles with valid data -> stall_cnt_o saturates at 15 and stays there. After rst_i it reads 0.
- SKID=0 build, dn_ready_i toggling at random over 200 beats -> scoreboard passes, up_ready_o=0 whenever hold=1, occ_o never 2.
